// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: op codes, FSM states and owner encoding shared by the memory arbiter
package mem_arb_pkg;
    localparam logic [2:0] OP_LB = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LW = 3'b010;
    localparam logic [2:0] OP_SB = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SW = 3'b110;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    typedef enum logic {ISSUE, RESP} state_t;

    function automatic logic [2:0] load_op(input logic [2:0] op);
        return (op[1:0] == 2'b11) ? OP_LW : op;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr=0 favours requester 0 on contention
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt[0] = req[0] && (!req[1] || !ptr);
        gnt[1] = req[1] && (!req[0] || ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance)
            ptr <= gnt[0];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin core/DMA arbiter sequencing single-cycle stores and two-cycle loads
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic [2:0]    c_op,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic [2:0]    d_op,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_stall,
    output logic [2:0]    m_op,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    state_t        state, state_nx;
    logic          own;
    logic [2:0]    lop;
    logic [AW-1:0] laddr;
    logic [1:0]    req, gnt;
    logic          any;
    logic [2:0]    wop;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    // rst masks requests so no grant escapes while reset is held
    assign req = (state == ISSUE && !rst) ? {d_req, c_req} : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .advance(any),
        .gnt    (gnt)
    );

    always_comb begin
        any      = |gnt;
        wop      = gnt[1] ? d_op    : c_op;
        waddr    = gnt[1] ? d_addr  : c_addr;
        wdata    = gnt[1] ? d_wdata : c_wdata;
        c_gnt    = gnt[0];
        d_gnt    = gnt[1];
        c_rvalid = state == RESP && own == OWN_CORE;
        d_rvalid = state == RESP && own == OWN_DMA;
        c_rdata  = m_rdata;
        d_rdata  = m_rdata;
        m_stall  = !any;
        m_op     = (state == RESP) ? lop   : (any ? wop   : 3'b000);
        m_addr   = (state == RESP) ? laddr : (any ? waddr : '0);
        m_wdata  = any ? wdata : '0;
        state_nx = (any && !wop[2]) ? RESP : ISSUE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ISSUE;
        else
            state <= state_nx;
    end

    // memory formats read data from op/addr in the response cycle, so hold them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own   <= OWN_CORE;
            lop   <= OP_LB;
            laddr <= '0;
        end else if (state_nx == RESP) begin
            own   <= gnt[1] ? OWN_DMA : OWN_CORE;
            lop   <= load_op(wop);
            laddr <= waddr;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench with a banked memory model behind the arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int          cyc;
        logic [3:0]  ev;
        logic [2:0]  op;
        logic [10:0] addr;
        logic        stall;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0, rst;
    logic        c_req, c_gnt, c_rvalid, d_req, d_gnt, d_rvalid, m_stall;
    logic [2:0]  c_op, d_op, m_op;
    logic [10:0] c_addr, d_addr, m_addr;
    logic [31:0] c_wdata, c_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
    logic [31:0] mem [512];
    exp_t        q[$];
    int          cyc = 0, vectors = 0, miscompares = 0;

    mem_arbiter #(.AW(11), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_stall(m_stall), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmt(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = off[1] ? w[31:16] : w[15:0];
        case (op[1:0])
            2'b00:   return {{24{b[7]}}, b};
            2'b01:   return {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    assign m_rdata = fmt(m_op, m_addr[1:0], mem[{m_addr[10], m_addr[9:2]}]);

    always @(posedge clk)
        if (!rst && !m_stall && m_op[2])
            case (m_op[1:0])
                2'b00: mem[{m_addr[10], m_addr[9:2]}][8*m_addr[1:0] +: 8] <= m_wdata[7:0];
                2'b01: mem[{m_addr[10], m_addr[9:2]}][16*m_addr[1] +: 16] <= m_wdata[15:0];
                2'b10: mem[{m_addr[10], m_addr[9:2]}] <= m_wdata;
                default: ;
            endcase

    // event encoding {c_gnt, d_gnt, c_rvalid, d_rvalid}
    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [31:0] ad;
        exp_t        e;
        ev = {c_gnt, d_gnt, c_rvalid, d_rvalid};
        if (ev != 4'b0000) begin
            vectors++;
            ad = ev[1] ? c_rdata : (ev[0] ? d_rdata : m_wdata);
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event cyc=%0d got ev=%b op=%b addr=%h data=%h, want none", cyc, ev, m_op, m_addr, ad);
            end else begin
                e = q.pop_front();
                if (cyc !== e.cyc || ev !== e.ev || m_op !== e.op || m_addr !== e.addr || m_stall !== e.stall || ad !== e.data) begin
                    miscompares++;
                    $display("FAIL event cyc=%0d got ev=%b op=%b addr=%h stall=%b data=%h, want cyc=%0d ev=%b op=%b addr=%h stall=%b data=%h",
                             cyc, ev, m_op, m_addr, m_stall, ad, e.cyc, e.ev, e.op, e.addr, e.stall, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic cr, input logic [2:0] co, input logic [10:0] ca, input logic [31:0] cw,
                       input logic dr, input logic [2:0] dop, input logic [10:0] da, input logic [31:0] dw);
        c_req = cr; c_op = co; c_addr = ca; c_wdata = cw;
        d_req = dr; d_op = dop; d_addr = da; d_wdata = dw;
    endtask

    task automatic eg(input bit d, input logic [2:0] op, input logic [10:0] a, input logic [31:0] w);
        q.push_back('{cyc, d ? 4'b0100 : 4'b1000, op, a, 1'b0, w});
    endtask

    task automatic er(input bit d, input logic [2:0] op, input logic [10:0] a, input logic [31:0] r);
        q.push_back('{cyc, d ? 4'b0001 : 4'b0010, op, a, 1'b1, r});
    endtask

    task automatic idle_checks(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(m_stall), 32'd1);
        chk({tag, "_gnt"}, 32'({c_gnt, d_gnt}), 32'd0);
        chk({tag, "_rvalid"}, 32'({c_rvalid, d_rvalid}), 32'd0);
        chk({tag, "_m_op"}, 32'(m_op), 32'd0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drv(1, OP_SW, 11'h004, 32'hDEADBEEF, 1, OP_SW, 11'h404, 32'h00008000);
        tick; tick;
        idle_checks("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        eg(0, OP_SW, 11'h004, 32'hDEADBEEF);
        tick; drv(1, OP_SW, 11'h008, 32'h11112222, 1, OP_SW, 11'h404, 32'h00008000);
        eg(1, OP_SW, 11'h404, 32'h00008000);
        tick; drv(1, OP_SW, 11'h008, 32'h11112222, 1, OP_SW, 11'h40C, 32'h33334444);
        eg(0, OP_SW, 11'h008, 32'h11112222);
        tick; drv(0, OP_LB, 11'h000, 0, 1, OP_SW, 11'h40C, 32'h33334444);
        eg(1, OP_SW, 11'h40C, 32'h33334444);
        tick; drv(0, OP_LB, 11'h000, 0, 0, OP_LB, 11'h000, 0);
        idle_checks("idle");
        tick; drv(1, OP_SW, 11'h004, 32'hDEADBEEF, 0, OP_LB, 11'h000, 0);
        eg(0, OP_SW, 11'h004, 32'hDEADBEEF);
        tick; drv(1, OP_LW, 11'h004, 0, 0, OP_LB, 11'h000, 0);
        eg(0, OP_LW, 11'h004, 0);
        tick; drv(1, OP_SW, 11'h404, 32'h00008000, 0, OP_LB, 11'h000, 0);
        er(0, OP_LW, 11'h004, 32'hDEADBEEF);
        tick; eg(0, OP_SW, 11'h404, 32'h00008000);
        tick; drv(1, OP_LB, 11'h405, 0, 0, OP_LB, 11'h000, 0);
        eg(0, OP_LB, 11'h405, 0);
        tick; drv(0, OP_LB, 11'h000, 0, 0, OP_LB, 11'h000, 0);
        er(0, OP_LB, 11'h405, 32'hFFFFFF80);
        tick; drv(0, OP_LB, 11'h000, 0, 1, 3'b011, 11'h40C, 0);
        eg(1, 3'b011, 11'h40C, 0);
        tick; drv(1, OP_LW, 11'h004, 0, 1, OP_LW, 11'h008, 0);
        er(1, OP_LW, 11'h40C, 32'h33334444);
        tick; eg(0, OP_LW, 11'h004, 0);
        tick; drv(1, OP_LW, 11'h404, 0, 1, OP_LW, 11'h008, 0);
        er(0, OP_LW, 11'h004, 32'hDEADBEEF);
        tick; eg(1, OP_LW, 11'h008, 0);
        tick; drv(1, OP_LW, 11'h404, 0, 1, OP_LW, 11'h40C, 0);
        er(1, OP_LW, 11'h008, 32'h11112222);
        tick; eg(0, OP_LW, 11'h404, 0);
        tick; drv(0, OP_LB, 11'h000, 0, 1, OP_LW, 11'h40C, 0);
        er(0, OP_LW, 11'h404, 32'h00008000);
        tick; eg(1, OP_LW, 11'h40C, 0);
        tick; drv(0, OP_LB, 11'h000, 0, 0, OP_LB, 11'h000, 0);
        er(1, OP_LW, 11'h40C, 32'h33334444);
        tick; drv(1, OP_LW, 11'h004, 0, 0, OP_LB, 11'h000, 0);
        eg(0, OP_LW, 11'h004, 0);
        tick; rst = 1'b1;
        drv(1, OP_LW, 11'h004, 0, 1, OP_LW, 11'h404, 0);
        idle_checks("midload_reset");
        tick; tick; rst = 1'b0;
        eg(0, OP_LW, 11'h004, 0);
        tick; drv(0, OP_LB, 11'h000, 0, 1, OP_LW, 11'h404, 0);
        er(0, OP_LW, 11'h004, 32'hDEADBEEF);
        tick; eg(1, OP_LW, 11'h404, 0);
        tick; drv(0, OP_LB, 11'h000, 0, 0, OP_LB, 11'h000, 0);
        er(1, OP_LW, 11'h404, 32'h00008000);
        tick; tick; tick;
        @(negedge clk);
        chk("pending_events", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
